// File: rtl/unified_cache_dm_param.sv
// unified_cache_dm_param
// Direct-mapped unified cache with one word per line. It sits between a
// single-outstanding CPU request port and on-board RAM. WRITE_BACK selects
// the write policy:
//   WRITE_BACK=0 : write-through. Every write updates the line and is then
//                  flushed to RAM.
//   WRITE_BACK=1 : write-back with write-allocate. Dirty victims are evicted
//                  before the line is replaced. A write miss installs the full
//                  word directly, with no RAM fetch.
//
// Ports
//   clka, rsta          clock and asynchronous active-low reset
//   ena, wea            request strobe (taken only when busy=0), 1=write
//   addra, dina         request word address and write data
//   douta, done, hit    read data; one-cycle completion pulse; hit flag
//                       (hit is valid together with done)
//   busy                request in progress
//   fetch, fetch_ack    RAM read strobe (held until ack); mem_rdata returns with ack
//   flush, flush_ack    RAM write strobe (held until ack); mem_wdata holds the data
//   mem_addr            RAM word address for the current fetch or flush
module unified_cache_dm_param #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int INDEX_W    = 10,
    parameter int WRITE_BACK = 0
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    output logic              done,
    output logic              hit,
    output logic              busy,
    output logic              fetch,
    output logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              fetch_ack,
    input  logic              flush_ack
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int DEPTH = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_EVICT, S_FETCH, S_FLUSH, S_INSTALL, S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    // Line storage. Only the valid and dirty bits are cleared by reset.
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag_mem  [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];

    // Request latched at acceptance, so the CPU may change its inputs afterwards.
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_din;
    logic              r_hit_lat;

    logic [DATA_W-1:0] r_douta, w_douta_nxt;
    logic              r_done, w_done_nxt;
    logic              r_hit, w_hit_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_fetch, w_fetch_nxt;
    logic              r_flush, w_flush_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              w_hit_lat_nxt;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [TAG_W-1:0]   w_line_tag;
    logic [DATA_W-1:0]  w_line_rdata;
    logic               w_hit;
    logic               w_victim_dirty;
    logic               w_accept;
    logic               w_line_we;
    logic               w_line_dirty;
    logic [DATA_W-1:0]  w_line_wdata;

    assign w_idx          = r_addr[INDEX_W-1:0];
    assign w_tag          = r_addr[ADDR_W-1:INDEX_W];
    assign w_line_tag     = r_tag_mem[w_idx];
    assign w_line_rdata   = r_data_mem[w_idx];
    assign w_hit          = r_valid[w_idx] && (w_line_tag == w_tag);
    // A victim needs eviction only in write-back mode. Write-through RAM is
    // always up to date.
    assign w_victim_dirty = (WRITE_BACK != 0) && r_valid[w_idx] && r_dirty[w_idx];
    assign w_accept       = (r_state == S_IDLE) && ena && !r_busy;

    always_comb begin
        w_state_nxt     = r_state;
        w_douta_nxt     = r_douta;
        w_done_nxt      = 1'b0;
        w_hit_nxt       = 1'b0;
        w_busy_nxt      = r_busy;
        w_fetch_nxt     = r_fetch;
        w_flush_nxt     = r_flush;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_hit_lat_nxt   = r_hit_lat;
        w_line_we       = 1'b0;
        w_line_dirty    = 1'b0;
        w_line_wdata    = r_din;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOOKUP;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_LOOKUP: begin
                if (!r_we) begin
                    if (w_hit) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_hit_nxt   = 1'b1;
                        w_douta_nxt = w_line_rdata;
                    end else if (w_victim_dirty) begin
                        w_state_nxt     = S_EVICT;
                        w_flush_nxt     = 1'b1;
                        w_mem_addr_nxt  = {w_line_tag, w_idx};
                        w_mem_wdata_nxt = w_line_rdata;
                    end else begin
                        w_state_nxt    = S_FETCH;
                        w_fetch_nxt    = 1'b1;
                        w_mem_addr_nxt = r_addr;
                    end
                end else if (WRITE_BACK == 0) begin
                    // Write-through: update the line now, remember the hit
                    // status for the completion pulse, then push the word to RAM.
                    w_line_we       = 1'b1;
                    w_hit_lat_nxt   = w_hit;
                    w_state_nxt     = S_FLUSH;
                    w_flush_nxt     = 1'b1;
                    w_mem_addr_nxt  = r_addr;
                    w_mem_wdata_nxt = r_din;
                end else if (w_hit) begin
                    w_line_we    = 1'b1;
                    w_line_dirty = 1'b1;
                    w_state_nxt  = S_DONE;
                    w_done_nxt   = 1'b1;
                    w_hit_nxt    = 1'b1;
                end else if (w_victim_dirty) begin
                    w_state_nxt     = S_EVICT;
                    w_flush_nxt     = 1'b1;
                    w_mem_addr_nxt  = {w_line_tag, w_idx};
                    w_mem_wdata_nxt = w_line_rdata;
                end else begin
                    w_state_nxt = S_INSTALL;
                end
            end
            S_EVICT: begin
                if (flush_ack) begin
                    w_flush_nxt = 1'b0;
                    if (!r_we) begin
                        w_state_nxt    = S_FETCH;
                        w_fetch_nxt    = 1'b1;
                        w_mem_addr_nxt = r_addr;
                    end else begin
                        w_state_nxt = S_INSTALL;
                    end
                end
            end
            S_FETCH: begin
                if (fetch_ack) begin
                    w_fetch_nxt  = 1'b0;
                    w_line_we    = 1'b1;
                    w_line_wdata = mem_rdata;
                    w_state_nxt  = S_DONE;
                    w_done_nxt   = 1'b1;
                    w_douta_nxt  = mem_rdata;
                end
            end
            S_FLUSH: begin
                if (flush_ack) begin
                    w_flush_nxt = 1'b0;
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_hit_nxt   = r_hit_lat;
                end
            end
            S_INSTALL: begin
                // Lines hold one full word, so a write miss needs no fetch.
                w_line_we    = 1'b1;
                w_line_dirty = 1'b1;
                w_state_nxt  = S_DONE;
                w_done_nxt   = 1'b1;
            end
            S_DONE: begin
                // busy stays high through the done cycle and drops afterwards.
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            r_state     <= S_IDLE;
            r_douta     <= '0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch     <= 1'b0;
            r_flush     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hit_lat   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_douta     <= w_douta_nxt;
            r_done      <= w_done_nxt;
            r_hit       <= w_hit_nxt;
            r_busy      <= w_busy_nxt;
            r_fetch     <= w_fetch_nxt;
            r_flush     <= w_flush_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_hit_lat   <= w_hit_lat_nxt;
        end
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_line_we) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= (WRITE_BACK != 0) && w_line_dirty;
        end
    end

    always_ff @(posedge clka) begin
        if (w_line_we) begin
            r_tag_mem[w_idx]  <= w_tag;
            r_data_mem[w_idx] <= w_line_wdata;
        end
        if (w_accept) begin
            r_addr <= addra;
            r_we   <= wea;
            r_din  <= dina;
        end
    end

    assign douta     = r_douta;
    assign done      = r_done;
    assign hit       = r_hit;
    assign busy      = r_busy;
    assign fetch     = r_fetch;
    assign flush     = r_flush;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_unified_cache_dm_param.sv
// Testbench for unified_cache_dm_param. It runs two instances: u=0 uses
// write-through and u=1 uses write-back. Both are checked against a word-level
// cache/RAM reference model.
module tb_unified_cache_dm_param;
    logic        clk = 1'b0;
    logic [1:0]  rst_n, ena, wea, done, hit, busy, fetch, flush, fetch_ack, flush_ack;
    logic [11:0] addra [2];
    logic [11:0] mem_addr [2];
    logic [31:0] dina [2];
    logic [31:0] douta [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    always #5 clk = ~clk;

    unified_cache_dm_param #(.ADDR_W(12), .DATA_W(32), .INDEX_W(10), .WRITE_BACK(0)) u_wt (
        .clka(clk), .rsta(rst_n[0]), .ena(ena[0]), .wea(wea[0]), .addra(addra[0]),
        .dina(dina[0]), .douta(douta[0]), .done(done[0]), .hit(hit[0]), .busy(busy[0]),
        .fetch(fetch[0]), .flush(flush[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .fetch_ack(fetch_ack[0]), .flush_ack(flush_ack[0]));

    unified_cache_dm_param #(.ADDR_W(12), .DATA_W(32), .INDEX_W(10), .WRITE_BACK(1)) u_wb (
        .clka(clk), .rsta(rst_n[1]), .ena(ena[1]), .wea(wea[1]), .addra(addra[1]),
        .dina(dina[1]), .douta(douta[1]), .done(done[1]), .hit(hit[1]), .busy(busy[1]),
        .fetch(fetch[1]), .flush(flush[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .fetch_ack(fetch_ack[1]), .flush_ack(flush_ack[1]));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: RAM contents plus, per cache line, which address it
    // holds and whether it is valid or dirty.
    logic [31:0] ram  [2][4096];
    bit          cv   [2][1024];
    bit          cd   [2][1024];
    logic [11:0] caddr[2][1024];
    logic [31:0] cdat [2][1024];
    logic [31:0] exp_dout [2];

    // Expected RAM transactions for the current request.
    int          nops;
    bit          op_f [4];
    logic [11:0] op_a [4];
    logic [31:0] op_d [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_op(input bit f, input logic [11:0] a, input logic [31:0] d);
        op_f[nops] = f;
        op_a[nops] = a;
        op_d[nops] = d;
        nops++;
    endtask

    // Runs one request through the DUT and checks it against the model.
    // hold: ack delay in cycles (-1 = random). poke: pulse ena while busy.
    task automatic req(input int u, input bit we, input logic [11:0] a, input logic [31:0] d,
                       input int hold, input bit poke);
        int          idx, cyc, wc, k, exp_lat;
        bit          ishit, exp_hit, started, seen_done;
        logic [11:0] vic;
        idx   = int'(a[9:0]);
        ishit = cv[u][idx] && (caddr[u][idx] == a);
        vic   = caddr[u][idx];
        nops  = 0;
        exp_lat = 0;
        exp_hit = 1'b0;
        if (!we) begin
            if (ishit) begin
                exp_hit = 1'b1;
                exp_lat = 2;
                exp_dout[u] = cdat[u][idx];
            end else begin
                if (u == 1 && cv[u][idx] && cd[u][idx]) begin
                    push_op(1'b0, vic, cdat[u][idx]);
                    ram[u][vic] = cdat[u][idx];
                end
                push_op(1'b1, a, ram[u][a]);
                cv[u][idx] = 1'b1; cd[u][idx] = 1'b0;
                caddr[u][idx] = a; cdat[u][idx] = ram[u][a];
                exp_dout[u] = ram[u][a];
            end
        end else if (u == 0) begin
            push_op(1'b0, a, d);
            ram[u][a] = d;
            exp_hit = ishit;
            cv[u][idx] = 1'b1; caddr[u][idx] = a; cdat[u][idx] = d;
        end else begin
            if (ishit) begin
                exp_hit = 1'b1;
                exp_lat = 2;
            end else if (cv[u][idx] && cd[u][idx]) begin
                push_op(1'b0, vic, cdat[u][idx]);
                ram[u][vic] = cdat[u][idx];
            end else begin
                exp_lat = 3;
            end
            cv[u][idx] = 1'b1; cd[u][idx] = 1'b1; caddr[u][idx] = a; cdat[u][idx] = d;
        end

        @(negedge clk);
        chk("idle_busy", busy[u], 1'b0);
        ena[u] = 1'b1; wea[u] = we; addra[u] = a; dina[u] = d;
        @(negedge clk);
        ena[u] = 1'b0; wea[u] = 1'($urandom); addra[u] = 12'($urandom); dina[u] = $urandom;
        k = 0; started = 1'b0; wc = 0; cyc = 1; seen_done = 1'b0;
        while (cyc < 60) begin
            fetch_ack[u] = 1'b0; flush_ack[u] = 1'b0; ena[u] = 1'b0;
            chk("busy", busy[u], 1'b1);
            if (done[u]) begin
                seen_done = 1'b1;
                break;
            end
            chk("fetch_and_flush", fetch[u] & flush[u], 1'b0);
            if (started) begin
                chk("strobe_held", op_f[k] ? fetch[u] : flush[u], 1'b1);
            end else if (fetch[u] | flush[u]) begin
                if (k >= nops) begin
                    chk("unexpected_ram_op", {fetch[u], flush[u]}, 2'b00);
                    break;
                end
                chk("op_is_fetch", fetch[u], op_f[k]);
                chk("mem_addr", mem_addr[u], op_a[k]);
                if (!op_f[k]) chk("mem_wdata", mem_wdata[u], op_d[k]);
                started = 1'b1;
                wc = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
            end
            if (started) begin
                if (wc == 0) begin
                    if (op_f[k]) begin
                        fetch_ack[u] = 1'b1;
                        mem_rdata[u] = op_d[k];
                    end else begin
                        flush_ack[u] = 1'b1;
                    end
                    k++;
                    started = 1'b0;
                end else begin
                    wc--;
                end
            end
            if (poke && cyc == 1) begin
                ena[u] = 1'b1; addra[u] = a ^ 12'h400; wea[u] = ~we;
            end
            @(negedge clk);
            cyc++;
        end
        fetch_ack[u] = 1'b0; flush_ack[u] = 1'b0; ena[u] = 1'b0;
        chk("done_seen", seen_done, 1'b1);
        if (seen_done) begin
            chk("ops_done", k, nops);
            chk("hit", hit[u], exp_hit);
            chk("douta", douta[u], exp_dout[u]);
            if (exp_lat != 0) chk("latency", cyc, exp_lat);
        end
        @(negedge clk);
        chk("done_pulse", done[u], 1'b0);
        chk("busy_clear", busy[u], 1'b0);
    endtask

    task automatic reset_mid_fetch(input int u, input logic [11:0] a);
        int n;
        @(negedge clk);
        ena[u] = 1'b1; wea[u] = 1'b0; addra[u] = a;
        @(negedge clk);
        ena[u] = 1'b0;
        n = 0;
        while (!fetch[u] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_fetch_seen", fetch[u], 1'b1);
        #2 rst_n[u] = 1'b0;
        #1;
        chk("rst_fetch_drop", fetch[u], 1'b0);
        chk("rst_busy_drop", busy[u], 1'b0);
        chk("rst_no_done", done[u], 1'b0);
        for (int i = 0; i < 1024; i++) begin
            cv[u][i] = 1'b0;
            cd[u][i] = 1'b0;
        end
        exp_dout[u] = '0;
        @(negedge clk);
        rst_n[u] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", done[u], 1'b0);
            chk("post_rst_busy", busy[u], 1'b0);
        end
    endtask

    initial begin
        rst_n = 2'b00; ena = '0; wea = '0; fetch_ack = '0; flush_ack = '0;
        for (int u = 0; u < 2; u++) begin
            addra[u] = '0; dina[u] = '0; mem_rdata[u] = '0; exp_dout[u] = '0;
            for (int i = 0; i < 4096; i++) ram[u][i] = $urandom;
            for (int i = 0; i < 1024; i++) begin
                cv[u][i] = 1'b0; cd[u][i] = 1'b0; caddr[u][i] = '0; cdat[u][i] = '0;
            end
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_douta", douta[u], 32'h0);
            chk("rst_done", done[u], 1'b0);
            chk("rst_hit", hit[u], 1'b0);
            chk("rst_busy", busy[u], 1'b0);
            chk("rst_fetch", fetch[u], 1'b0);
            chk("rst_flush", flush[u], 1'b0);
            chk("rst_mem_addr", mem_addr[u], 12'h0);
            chk("rst_mem_wdata", mem_wdata[u], 32'h0);
        end
        rst_n = 2'b11;

        // Write-through instance: fetch, hit, held flush, conflict misses.
        ram[0][12'h005] = 32'hDEADBEEF;
        req(0, 1'b0, 12'h005, 32'h0, 0, 1'b0);
        req(0, 1'b0, 12'h005, 32'h0, 0, 1'b0);
        req(0, 1'b1, 12'h123, 32'h0000CAFE, 5, 1'b0);
        req(0, 1'b0, 12'h123, 32'h0, 0, 1'b0);
        req(0, 1'b0, 12'h405, 32'h0, 1, 1'b0);
        req(0, 1'b0, 12'h005, 32'h0, 0, 1'b0);
        req(0, 1'b0, 12'h005, 32'h0, 0, 1'b1);
        req(0, 1'b1, 12'h005, 32'h12345678, 2, 1'b1);

        // Acks while idle must be ignored.
        @(negedge clk);
        fetch_ack = 2'b11; flush_ack = 2'b11;
        @(negedge clk);
        fetch_ack = 2'b00; flush_ack = 2'b00;
        for (int u = 0; u < 2; u++) begin
            chk("idle_ack_done", done[u], 1'b0);
            chk("idle_ack_busy", busy[u], 1'b0);
            chk("idle_ack_strobes", {fetch[u], flush[u]}, 2'b00);
        end
        req(0, 1'b0, 12'h005, 32'h0, 0, 1'b0);

        // Write-back instance: install, dirty eviction, clean victim.
        req(1, 1'b1, 12'h007, 32'h00000011, 0, 1'b0);
        req(1, 1'b0, 12'h407, 32'h0, 0, 1'b0);
        req(1, 1'b0, 12'h007, 32'h0, 2, 1'b0);
        req(1, 1'b1, 12'h007, 32'h00000022, 0, 1'b1);
        req(1, 1'b1, 12'h807, 32'h00000033, 3, 1'b0);

        // Reset during a fetch aborts it and invalidates the cache.
        reset_mid_fetch(0, 12'h805);
        req(0, 1'b0, 12'h005, 32'h0, 0, 1'b0);

        // Randomized traffic on a small address pool to force hits and conflicts.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 150; n++) begin
                req(u, 1'($urandom), {2'($urandom_range(0, 3)), 7'd0, 3'($urandom_range(0, 7))},
                    $urandom, -1, ($urandom_range(0, 7) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
